// File: rtl/cpu_run_controller_if.sv
// Run-control bundle between the board debug logic (master) and the
// 6502 RDY sequencer (slave).
interface cpu_run_controller_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic        bp_enable;
  logic [15:0] bp_addr;
  logic [15:0] cpu_addr;
  logic        cnt_clr;
  logic        cpu_rdy;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] cycle_count;

  modport master (
    output run_req, halt_req, step_req, bp_enable, bp_addr, cpu_addr, cnt_clr,
    input  cpu_rdy, state, bp_hit, cycle_count
  );

  modport slave (
    input  run_req, halt_req, step_req, bp_enable, bp_addr, cpu_addr, cnt_clr,
    output cpu_rdy, state, bp_hit, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Drives the 6502 RDY line: run at a divided rate, halt, single-step and
// stop before the CPU executes a cycle presenting the breakpoint address.
module cpu_run_controller #(
  parameter int unsigned DIVIDER      = 12_500_000,
  parameter int unsigned DIV_W        = 24,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_e;

  localparam state_e           RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIVIDER - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             skip_q, skip_d;
  logic             rdy_q, rdy_d;
  logic             hit_q, hit_d;
  logic             from_brk_q, from_brk_d;
  logic [31:0]      cnt_q, cnt_d;

  logic tick;
  logic bp_match;

  assign tick     = (div_q == DIV_LAST);
  assign bp_match = bus.bp_enable && (bus.cpu_addr == bus.bp_addr) && !skip_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    skip_d     = skip_q;
    rdy_d      = 1'b0;
    hit_d      = 1'b0;
    from_brk_d = from_brk_q;
    // The count reflects RDY as the CPU saw it at this edge.
    cnt_d      = bus.cnt_clr ? 32'd0 : cnt_q + {31'd0, rdy_q};

    unique case (state_q)
      ST_HALT: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.step_req) begin
          state_d    = ST_STEP;
          rdy_d      = 1'b1;
          from_brk_d = 1'b0;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end

      ST_RUN: begin
        // Once the CPU has consumed one enabled cycle it has moved off the
        // breakpoint address, so the breakpoint can be re-armed.
        if (rdy_q) begin
          skip_d = 1'b0;
        end
        if (bus.halt_req) begin
          state_d = ST_HALT;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick && bp_match) begin
            state_d = ST_BRK;
            hit_d   = 1'b1;
          end else begin
            rdy_d = tick;
          end
        end
      end

      ST_STEP: begin
        state_d = (bus.halt_req || !from_brk_q) ? ST_HALT : ST_BRK;
      end

      ST_BRK: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.step_req) begin
          state_d    = ST_STEP;
          rdy_d      = 1'b1;
          from_brk_d = 1'b1;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      div_q      <= '0;
      skip_q     <= 1'b0;
      rdy_q      <= 1'b0;
      hit_q      <= 1'b0;
      from_brk_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      skip_q     <= skip_d;
      rdy_q      <= rdy_d;
      hit_q      <= hit_d;
      from_brk_q <= from_brk_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.cpu_rdy     = rdy_q;
  assign bus.state       = state_q;
  assign bus.bp_hit      = hit_q;
  assign bus.cycle_count = cnt_q;

endmodule
